// File: rtl/sram_d_arbiter.sv
// sram_d_arbiter: merges two OBI masters (m0 = core data, m1 = host bridge)
// onto one SRAM data port. An in-order owner FIFO routes each response back
// to the master that issued it, together with the SRAM illegal-address flag
// captured at accept time as a per-response error.
//
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Default (undefined) is fixed priority to m0 with a starvation cap of
// MAX_BURST consecutive m0 grants while m1 waits.
//
// Handshake: a request is accepted in a cycle where sram_d_req_o and
// sram_d_gnt_i are both high; only then does the winner see its gnt and is
// an owner entry pushed. A response is consumed in any cycle with
// sram_d_rvalid_i high; there is no backpressure on responses.
module sram_d_arbiter #(
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [31:0] m1_rdata_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic        sram_d_req_o,
  input  logic        sram_d_gnt_i,
  output logic [31:0] sram_d_addr_o,
  output logic        sram_d_we_o,
  output logic [3:0]  sram_d_be_o,
  output logic [31:0] sram_d_wdata_o,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,
  input  logic        sram_d_illegal_i,
  output logic        stray_rvalid_o
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef struct packed {
    logic owner;    // 0 = m0, 1 = m1
    logic illegal;  // SRAM flagged the address at accept time
  } fifo_entry_t;

  fifo_entry_t      mem_q [FIFO_DEPTH];
  fifo_entry_t      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             stray_q, stray_d;

  logic        empty, full, pop, stall, any_req, sel_m1, accept;
  fifo_entry_t head;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
  assign pop     = sram_d_rvalid_i & ~empty;
  // A response popping this cycle frees a slot, so a full FIFO only stalls
  // issue when nothing is coming back.
  assign stall   = full & ~pop;
  assign any_req = m0_req_i | m1_req_i;
  assign head    = mem_q[rptr_q[IDX_W-1:0]];

  // Outputs are gated by rst_ni so they drop to zero as soon as reset asserts.
  assign sram_d_req_o = any_req & ~stall & rst_ni;
  assign accept       = sram_d_req_o & sram_d_gnt_i;
  assign m0_gnt_o     = accept & ~sel_m1;
  assign m1_gnt_o     = accept & sel_m1;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;  // last accepted master; reset to m1 so m0 goes first

  assign sel_m1 = m1_req_i & (~m0_req_i | ~last_q);

  // Round-robin pointer moves only when a request is actually accepted.
  always_comb begin
    last_d = last_q;
    if (accept) last_d = sel_m1;
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  localparam logic [3:0] MAX_B = 4'(MAX_BURST);
  logic [3:0] burst_q, burst_d;  // consecutive m0 accepts while m1 waits

  assign sel_m1 = m1_req_i & (~m0_req_i | (burst_q == MAX_B));

  // Count m0 wins against a waiting m1; clear once m1 is served or leaves.
  always_comb begin
    burst_d = burst_q;
    if (!m1_req_i)             burst_d = 4'd0;
    else if (accept && sel_m1) burst_d = 4'd0;
    else if (accept)           burst_d = burst_q + 4'd1;
  end

  // Burst counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) burst_q <= 4'd0;
    else         burst_q <= burst_d;
  end
`endif

  // Request field mux from the winner; zero when nobody is requesting.
  always_comb begin
    sram_d_addr_o  = 32'd0;
    sram_d_we_o    = 1'b0;
    sram_d_be_o    = 4'd0;
    sram_d_wdata_o = 32'd0;
    if (any_req && rst_ni) begin
      sram_d_addr_o  = sel_m1 ? m1_addr_i  : m0_addr_i;
      sram_d_we_o    = sel_m1 ? m1_we_i    : m0_we_i;
      sram_d_be_o    = sel_m1 ? m1_be_i    : m0_be_i;
      sram_d_wdata_o = sel_m1 ? m1_wdata_i : m0_wdata_i;
    end
  end

  // Route the head response to its owner; the other master sees zeros.
  always_comb begin
    m0_rvalid_o = pop & ~head.owner;
    m1_rvalid_o = pop & head.owner;
    m0_rdata_o  = m0_rvalid_o ? sram_d_rdata_i : 32'd0;
    m1_rdata_o  = m1_rvalid_o ? sram_d_rdata_i : 32'd0;
    m0_err_o    = m0_rvalid_o & head.illegal;
    m1_err_o    = m1_rvalid_o & head.illegal;
  end

  assign stray_rvalid_o = stray_q;

  // Owner FIFO next state: push on accept, pop on response, sticky stray flag.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    stray_d = stray_q | (sram_d_rvalid_i & empty);
    if (accept) begin
      mem_d[wptr_q[IDX_W-1:0]] = '{owner: sel_m1, illegal: sram_d_illegal_i};
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
  end

  // FIFO and flag registers; reset drops any pending entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      stray_q <= stray_d;
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed testbench for sram_d_arbiter. Inputs change on the falling edge,
// outputs are checked 1 ns later, and the DUT acts on the next rising edge.
// The SRAM side is driven by hand: rvalid is raised one cycle after accept.
module tb_sram_d_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        sram_d_req_o, sram_d_gnt_i, sram_d_we_o;
  logic [31:0] sram_d_addr_o, sram_d_wdata_o, sram_d_rdata_i;
  logic [3:0]  sram_d_be_o;
  logic        sram_d_rvalid_i, sram_d_illegal_i, stray_rvalid_o;

  int checks = 0;
  int errors = 0;

  sram_d_arbiter #(.MAX_BURST(4), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_be_i(m0_be_i), .m1_be_i(m1_be_i),
    .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
    .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
    .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
    .sram_d_req_o(sram_d_req_o), .sram_d_gnt_i(sram_d_gnt_i),
    .sram_d_addr_o(sram_d_addr_o), .sram_d_we_o(sram_d_we_o),
    .sram_d_be_o(sram_d_be_o), .sram_d_wdata_o(sram_d_wdata_o),
    .sram_d_rvalid_i(sram_d_rvalid_i), .sram_d_rdata_i(sram_d_rdata_i),
    .sram_d_illegal_i(sram_d_illegal_i), .stray_rvalid_o(stray_rvalid_o)
  );

  // Clock generation.
  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    m0_req_i = 0; m1_req_i = 0;
    m0_addr_i = 0; m1_addr_i = 0; m0_wdata_i = 0; m1_wdata_i = 0;
    m0_we_i = 0; m1_we_i = 0; m0_be_i = 4'hF; m1_be_i = 4'hF;
    sram_d_gnt_i = 1; sram_d_rvalid_i = 0; sram_d_rdata_i = 0; sram_d_illegal_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'hDEAD_BEEF; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h55;
    @(negedge clk_i); #1;
    checks++; if (sram_d_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", sram_d_req_o); end
    checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected 00", {m0_gnt_o, m1_gnt_o}); end
    checks++; if (sram_d_addr_o !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h expected 0", sram_d_addr_o); end
    checks++; if ({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 4'b0) begin errors++; $display("FAIL rst_rsp: got %b expected 0000", {m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}); end
    checks++; if (stray_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_stray: got %b expected 0", stray_rvalid_o); end
    idle_inputs();
    @(negedge clk_i); rst_ni = 1;
  endtask

  // Both masters request continuously for 10 cycles; check winners and routing.
  task automatic test_arbitration();
    logic exp_m1;
    logic own [10];
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      m0_req_i = (i < 10); m1_req_i = (i < 10);
      m0_addr_i = 32'h100 + 32'(i); m1_addr_i = 32'h200 + 32'(i);
      sram_d_rvalid_i = (i > 0); sram_d_rdata_i = 32'(i);
      #1;
      if (i < 10) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_m1 = (i % 2 == 1);
`else
        exp_m1 = (i % 5 == 4);
`endif
        own[i] = exp_m1;
        checks++; if ({m1_gnt_o, m0_gnt_o} !== {exp_m1, ~exp_m1}) begin errors++; $display("FAIL arb_gnt[%0d]: got m1,m0=%b expected %b", i, {m1_gnt_o, m0_gnt_o}, {exp_m1, ~exp_m1}); end
        checks++; if (sram_d_addr_o !== (exp_m1 ? 32'h200 + 32'(i) : 32'h100 + 32'(i))) begin errors++; $display("FAIL arb_addr[%0d]: got %h", i, sram_d_addr_o); end
      end
      if (i > 0) begin
        checks++;
        if ({m1_rvalid_o, m0_rvalid_o} !== {own[i-1], ~own[i-1]} ||
            (own[i-1] ? m1_rdata_o : m0_rdata_o) !== 32'(i) ||
            (own[i-1] ? m0_rdata_o : m1_rdata_o) !== 32'd0) begin
          errors++;
          $display("FAIL arb_rsp[%0d]: got rv m1,m0=%b rd0=%h rd1=%h expected owner m1=%b data %0d", i, {m1_rvalid_o, m0_rvalid_o}, m0_rdata_o, m1_rdata_o, own[i-1], i);
        end
      end
    end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_single_read();
    @(negedge clk_i);
    m0_req_i = 1; m0_addr_i = 32'h8000_0010;
    #1;
    checks++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin errors++; $display("FAIL rd_gnt: got m0=%b m1=%b expected 1 0", m0_gnt_o, m1_gnt_o); end
    checks++; if (sram_d_req_o !== 1'b1 || sram_d_addr_o !== 32'h8000_0010 || sram_d_we_o !== 1'b0) begin errors++; $display("FAIL rd_fields: got req=%b addr=%h we=%b", sram_d_req_o, sram_d_addr_o, sram_d_we_o); end
    @(negedge clk_i);
    m0_req_i = 0; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h1234_5678;
    #1;
    checks++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h1234_5678 || m0_err_o !== 1'b0) begin errors++; $display("FAIL rd_rsp: got rv=%b rd=%h err=%b expected 1 12345678 0", m0_rvalid_o, m0_rdata_o, m0_err_o); end
    checks++; if ({m1_rvalid_o, m1_err_o, m1_gnt_o} !== 3'b0 || m1_rdata_o !== 32'd0) begin errors++; $display("FAIL rd_m1_quiet: got %b %h expected zeros", {m1_rvalid_o, m1_err_o, m1_gnt_o}, m1_rdata_o); end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_illegal();
    @(negedge clk_i);
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h7FFF_FFF0; m1_wdata_i = 32'hAAAA_5555; m1_be_i = 4'h3; sram_d_illegal_i = 1;
    #1;
    checks++; if (m1_gnt_o !== 1'b1 || sram_d_we_o !== 1'b1 || sram_d_be_o !== 4'h3 || sram_d_wdata_o !== 32'hAAAA_5555) begin errors++; $display("FAIL ill_req: got gnt=%b we=%b be=%h wd=%h", m1_gnt_o, sram_d_we_o, sram_d_be_o, sram_d_wdata_o); end
    @(negedge clk_i);
    m1_req_i = 0; m1_we_i = 0; sram_d_illegal_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h40; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h0;
    #1;
    checks++; if (m1_rvalid_o !== 1'b1 || m1_err_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin errors++; $display("FAIL ill_rsp: got m1 rv=%b err=%b m0 rv=%b expected 1 1 0", m1_rvalid_o, m1_err_o, m0_rvalid_o); end
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("FAIL ill_push_pop_gnt: got %b expected 1", m0_gnt_o); end
    @(negedge clk_i);
    m0_req_i = 0; sram_d_rdata_i = 32'h77;
    #1;
    checks++; if (m0_rvalid_o !== 1'b1 || m0_err_o !== 1'b0 || m0_rdata_o !== 32'h77) begin errors++; $display("FAIL ill_next_ok: got rv=%b err=%b rd=%h expected 1 0 77", m0_rvalid_o, m0_err_o, m0_rdata_o); end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_interleave();
    @(negedge clk_i);
    m0_req_i = 1; m0_addr_i = 32'h10;
    #1;
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("FAIL il_gnt0: got %b expected 1", m0_gnt_o); end
    @(negedge clk_i);
    m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h20; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'hA;
    #1;
    checks++; if (m1_gnt_o !== 1'b1 || m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA || m1_rvalid_o !== 1'b0) begin errors++; $display("FAIL il_rsp0: got gnt1=%b rv0=%b rd0=%h rv1=%b expected 1 1 a 0", m1_gnt_o, m0_rvalid_o, m0_rdata_o, m1_rvalid_o); end
    @(negedge clk_i);
    m1_req_i = 0; sram_d_rdata_i = 32'hB;
    #1;
    checks++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hB || m0_rvalid_o !== 1'b0 || m0_rdata_o !== 32'd0) begin errors++; $display("FAIL il_rsp1: got rv1=%b rd1=%h rv0=%b rd0=%h expected 1 b 0 0", m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o); end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_gnt_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      m0_req_i = 1; m0_addr_i = 32'h0000_0100; m0_wdata_i = 32'h0BAD_F00D; m0_we_i = 1; sram_d_gnt_i = 0;
      sram_d_rvalid_i = (i == 1);
      #1;
      checks++; if (m0_gnt_o !== 1'b0 || sram_d_req_o !== 1'b1 || sram_d_addr_o !== 32'h100 || sram_d_wdata_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL stall[%0d]: got gnt=%b req=%b addr=%h wd=%h", i, m0_gnt_o, sram_d_req_o, sram_d_addr_o, sram_d_wdata_o); end
      checks++; if (stray_rvalid_o !== (i == 2)) begin errors++; $display("FAIL stall_stray[%0d]: got %b expected %b", i, stray_rvalid_o, (i == 2)); end
    end
    @(negedge clk_i);
    sram_d_gnt_i = 1; sram_d_rvalid_i = 0;
    #1;
    checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("FAIL stall_release_gnt: got %b expected 1", m0_gnt_o); end
    @(negedge clk_i);
    m0_req_i = 0; m0_we_i = 0; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h5;
    #1;
    checks++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h5 || stray_rvalid_o !== 1'b1) begin errors++; $display("FAIL stall_rsp: got rv=%b rd=%h stray=%b expected 1 5 1", m0_rvalid_o, m0_rdata_o, stray_rvalid_o); end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      m0_req_i = 1; m0_addr_i = 32'h300 + 32'(i);
      #1;
      checks++; if (m0_gnt_o !== 1'b1) begin errors++; $display("FAIL full_fill[%0d]: got %b expected 1", i, m0_gnt_o); end
    end
    @(negedge clk_i); #1;
    checks++; if (sram_d_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin errors++; $display("FAIL full_stall: got req=%b gnt=%b expected 0 0", sram_d_req_o, m0_gnt_o); end
    @(negedge clk_i);
    sram_d_rvalid_i = 1; sram_d_rdata_i = 32'd1;
    #1;
    checks++; if (sram_d_req_o !== 1'b1 || m0_gnt_o !== 1'b1 || m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'd1) begin errors++; $display("FAIL full_pop_issue: got req=%b gnt=%b rv=%b rd=%h expected 1 1 1 1", sram_d_req_o, m0_gnt_o, m0_rvalid_o, m0_rdata_o); end
    for (int i = 2; i < 4; i++) begin
      @(negedge clk_i);
      m0_req_i = 0; sram_d_rdata_i = 32'(i);
      #1;
      checks++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'(i)) begin errors++; $display("FAIL full_drain[%0d]: got rv=%b rd=%h", i, m0_rvalid_o, m0_rdata_o); end
    end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    m1_req_i = 1; m1_addr_i = 32'h44;
    @(negedge clk_i);
    m1_req_i = 0; m0_req_i = 1;
    #2;
    rst_ni = 0; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h99;
    #1;
    checks++; if ({sram_d_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, stray_rvalid_o} !== 8'b0) begin errors++; $display("FAIL mid_rst_ctrl: got %b expected 00000000", {sram_d_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, stray_rvalid_o}); end
    checks++; if (sram_d_addr_o !== 32'd0 || m1_rdata_o !== 32'd0 || m0_rdata_o !== 32'd0) begin errors++; $display("FAIL mid_rst_data: got addr=%h rd0=%h rd1=%h expected 0", sram_d_addr_o, m0_rdata_o, m1_rdata_o); end
    @(negedge clk_i);
    idle_inputs(); rst_ni = 1;
    @(negedge clk_i);
    m1_req_i = 1; m1_addr_i = 32'h48;
    #1;
    checks++; if (m1_gnt_o !== 1'b1) begin errors++; $display("FAIL mid_new_gnt: got %b expected 1", m1_gnt_o); end
    @(negedge clk_i);
    m1_req_i = 0; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'hCAFE;
    #1;
    checks++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hCAFE || m1_err_o !== 1'b0 || stray_rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_new_rsp: got rv=%b rd=%h err=%b stray=%b expected 1 cafe 0 0", m1_rvalid_o, m1_rdata_o, m1_err_o, stray_rvalid_o); end
    @(negedge clk_i); idle_inputs();
  endtask

  // Test sequence; arbitration runs right after reset so the pointer starts at m0.
  initial begin
    test_reset();
    test_arbitration();
    test_single_read();
    test_illegal();
    test_interleave();
    test_gnt_stall();
    test_fifo_full();
    test_reset_mid();
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_d_arbiter.md
# sram_d_arbiter

Two-master OBI arbiter that merges the core data port (m0) and the host/Wishbone bridge port (m1) onto the single SRAM data port feeding `sram_wrap`. It holds a small in-order owner FIFO so each `sram_d_rvalid_i` response is routed to the master that issued the request. It also returns the SRAM illegal-address indication to that master as a per-response error.

## Interface
- `MAX_BURST`, default 4: consecutive grants m0 may take while m1 is waiting (fixed-priority mode only); legal range 1–15.
- `FIFO_DEPTH`, default 2: owner FIFO entries; power of two, ≥2.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `m0_req_i`, `m1_req_i` in 1: master request.
- `m0_gnt_o`, `m1_gnt_o` out 1: master grant, combinational.
- `m0_addr_i`, `m1_addr_i` in 32: byte address.
- `m0_we_i`, `m1_we_i` in 1: write enable.
- `m0_be_i`, `m1_be_i` in 4: byte enables.
- `m0_wdata_i`, `m1_wdata_i` in 32: write data.
- `m0_rvalid_o`, `m1_rvalid_o` out 1: response valid.
- `m0_rdata_o`, `m1_rdata_o` out 32: response data.
- `m0_err_o`, `m1_err_o` out 1: response error, valid with rvalid.
- `sram_d_req_o` out 1: request to SRAM.
- `sram_d_gnt_i` in 1: SRAM grant.
- `sram_d_addr_o` out 32, `sram_d_we_o` out 1, `sram_d_be_o` out 4, `sram_d_wdata_o` out 32: muxed request fields.
- `sram_d_rvalid_i` in 1, `sram_d_rdata_i` in 32: SRAM response.
- `sram_d_illegal_i` in 1: data-side illegal-address flag; combinational, valid in the request cycle.
- `stray_rvalid_o` out 1: sticky flag, set when an rvalid arrives with the FIFO empty.

## Operation
- Accept condition: `sram_d_req_o && sram_d_gnt_i`. The winning master's `mN_gnt_o` equals `sram_d_gnt_i` in that cycle. The losing master sees `gnt = 0` and keeps its request held.
- Request fields mux from the winner. When no master is selected, all request fields are driven to 0.
- `sram_d_req_o = (m0_req_i | m1_req_i) & ~stall`.
  - `stall` = FIFO full and no pop this cycle.
  - A pop in the same cycle as a full FIFO frees the slot, so issue proceeds.
- On accept, push {owner, `sram_d_illegal_i`} into the owner FIFO.
- On `sram_d_rvalid_i`, pop the head entry:
  - drive `mOwner_rvalid_o = 1`, `mOwner_rdata_o = sram_d_rdata_i`, `mOwner_err_o = head.illegal`;
  - the other master's rvalid is 0 and its rdata is 0.
- Simultaneous push and pop are legal; occupancy is unchanged.
- Pop with the FIFO empty: the response is discarded, `stray_rvalid_o` is set, and it stays set until reset.
- Responses are strictly in order; masters never see reordering.
- Arbitration (fixed-priority mode):
  - m0 wins ties.
  - Burst counter `burst_q` (4 bits) increments on each m0 accept while `m1_req_i = 1`.
  - When `burst_q == MAX_BURST`, m1 wins the next contended cycle and the counter clears.
  - The counter also clears on any m1 accept or whenever `m1_req_i = 0`.

## Timing
- Grant is combinational, with zero added request latency. Response latency equals SRAM latency (1 cycle after accept for `sram_wrap`); the response path is combinational from `sram_d_rvalid_i`.
- Back-to-back accepts every cycle are sustained at FIFO_DEPTH = 2 with 1-cycle SRAM latency.
- Reset values: all `mN_gnt_o`, `mN_rvalid_o`, `mN_err_o` and `sram_d_req_o` are 0; all data/addr/be outputs are 0; `stray_rvalid_o` is 0; FIFO is empty; `burst_q` is 0; round-robin pointer is set so m0 has priority.
- Reset asserted mid-transaction: pending FIFO entries are dropped with no response to the masters. An rvalid arriving in the first cycle after release sets `stray_rvalid_o`. Verification treats this as expected.
- FIFO pointers are one bit wider than log2(FIFO_DEPTH) and wrap modulo 2·depth:
  - full = MSBs differ and lower bits are equal;
  - empty = pointers equal.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - Pointer `last_q` records the last accepted master.
  - On contention the other master wins.
  - Pointer updates only on accept.
  - `burst_q` and `MAX_BURST` are unused.
- Not defined: fixed priority with the m0 starvation cap described under Operation.

## Test plan
- m0 reads 0x8000_0010 alone, SRAM returns 0x1234_5678 → `m0_gnt_o` is 1 in the request cycle; `m0_rvalid_o` is 1 with rdata 0x1234_5678 and err 0 one cycle later; m1 outputs stay 0.
- m0 and m1 both request continuously for 10 cycles, fixed mode, MAX_BURST = 4 → accept sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1. With `SRAM_ARB_ROUND_ROBIN_EN` → m0,m1,m0,m1,…
- m1 write to 0x7FFF_FFF0 with `sram_d_illegal_i = 1` → `m1_rvalid_o = 1` and `m1_err_o = 1` next cycle; the following m0 read returns err 0.
- Interleaved m0 read / m1 read on consecutive cycles with SRAM data 0xA, 0xB → m0 receives 0xA, then m1 receives 0xB, each exactly one cycle after its accept.
- `sram_d_gnt_i` forced to 0 for 3 cycles with m0 requesting → `m0_gnt_o = 0` throughout, request fields held stable, FIFO is not pushed. Injecting an rvalid in that window sets `stray_rvalid_o`.
- Assert `rst_ni` low while one response is pending → all outputs are 0 immediately (asynchronously). After release, a new m1 read completes normally.
